id_operand_stage: RTL and testbench
===================================

ID_OPERAND_STAGE -- requirements
Module: id_operand_stage

Interface
REQ-001 SHALL have parameter REGI_BITS, default 4, meaning integer register address width.
REQ-002 SHALL have parameter REGI_SIZE, default 16, meaning integer register data width.
REQ-003 SHALL have parameter VECT_BITS, default 2, meaning vector register address width.
REQ-004 SHALL have parameter VECT_SIZE, default 8, meaning lanes per vector register.
REQ-005 SHALL have parameter ELEM_SIZE, default 8, meaning lane width.
REQ-006 SHALL have parameter CTRL_W, default 32, meaning width of the opaque decoded-control bundle.
REQ-007 SHALL have parameter SB_BITS, default 2, meaning per-register outstanding-write counter width.
REQ-008 SHALL have ports: clk in 1, the single clock. rst in 1, asynchronous active-low reset.
REQ-009 SHALL have ports: in_valid_i in 1, in_ready_o out 1, pc_i in REGI_SIZE, ctrl_i in CTRL_W.
REQ-010 SHALL have ports: ra1_i, ra2_i in REGI_BITS; va1_i, va2_i in VECT_BITS; use_i in 4, source-used flags {vs2,vs1,rs2,rs1}.
REQ-011 SHALL have ports: rd_i in REGI_BITS, vd_i in VECT_BITS, int_wr_i in 1, vec_wr_i in 1 (destination and write intent).
REQ-012 SHALL have ports: int_we_i in 1, int_dest_i in REGI_BITS, int_wd_i in REGI_SIZE, vec_we_i in 1, vec_dest_i in VECT_BITS, vec_wd_i in ELEM_SIZE*VECT_SIZE (writeback).
REQ-013 SHALL have ports: flush_i in 1, out_ready_i in 1, out_valid_o out 1.
REQ-014 SHALL have ports: intOper1_o, intOper2_o, pc_o out REGI_SIZE; vOper1_o, vOper2_o out ELEM_SIZE*VECT_SIZE; ctrl_o out CTRL_W.
REQ-015 SHALL have ports: int_dest_o out REGI_BITS, vec_dest_o out VECT_BITS, int_wr_o, vec_wr_o out 1.

Function
REQ-016 SHALL contain 2**REGI_BITS integer and 2**VECT_BITS vector registers, written at posedge clk when int_we_i/vec_we_i.
REQ-017 SHALL return pc_i for reads of integer index 2**REGI_BITS-1 (PC alias); writes to it ignored, never scoreboarded.
REQ-018 SHALL bypass: a read whose address equals a same-cycle asserted writeback address returns the writeback data.
REQ-019 SHALL keep a SB_BITS counter per integer and per vector register (PC alias excluded).
REQ-020 SHALL increment the destination counter when the ID/EX entry leaves (out_valid_o && out_ready_i) with int_wr_o/vec_wr_o set.
REQ-021 SHALL decrement a counter on matching writeback; simultaneous increment and decrement leave it unchanged; decrement at zero is ignored.
REQ-022 SHALL compute pending(r) = count(r) + (ID/EX valid writer of r) - (writeback to r this cycle) > 0.
REQ-023 SHALL assert hazard when any used source is pending, or the destination counter equals 2**SB_BITS-1 (WAW saturation).
REQ-024 SHALL drive in_ready_o = !hazard && (!out_valid_o || out_ready_i) combinationally; fire = in_valid_i && in_ready_o.
REQ-025 SHALL, on fire, capture operands, pc_i, ctrl_i, dest and wr flags into ID/EX and set out_valid_o next cycle (latency 1).
REQ-026 SHALL hold all ID/EX outputs stable while out_valid_o && !out_ready_i.
REQ-027 SHALL clear out_valid_o when a leave occurs without fire; otherwise leave it unchanged.
REQ-028 SHALL, on flush_i, clear out_valid_o next cycle, suppress fire, and suppress the scoreboard increment that cycle.
REQ-029 SHALL leave counters of instructions already past ID/EX intact on flush_i.

Reset
REQ-030 SHALL, while rst=0, asynchronously zero all registers, counters, ID/EX fields and out_valid_o; in_ready_o=1 after release.
REQ-031 SHALL, on reset mid-stall, discard the held entry; no writeback is expected after reset.

Verification
REQ-032 Write r3=0x1234 via writeback, next cycle issue ra1=3 -> intOper1_o=0x1234, out_valid_o one cycle after fire.
REQ-033 Same-cycle writeback v1=0x0102030405060708 and issue va1=1 -> vOper1_o=0x0102030405060708 (bypass).
REQ-034 Issue writer rd=5, leave; issue reader ra2=5 -> in_ready_o=0 until writeback r5, fire in that cycle, operand=wd.
REQ-035 Three leaving writers to r2 with SB_BITS=2, fourth writer r2 -> stalled; one writeback r2 -> fourth fires.
REQ-036 out_ready_i=0 for 4 cycles with entry held -> outputs stable, in_ready_o=0; flush_i -> out_valid_o=0, counters unchanged.
REQ-037 Read ra1=15 with pc_i=0x0040 -> intOper1_o=0x0040; rst low mid-operation -> all outputs 0 immediately.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode/operand-fetch stage: integer and vector register files with PC alias and
// writeback bypass, per-register outstanding-write scoreboard, and the ID/EX register.
module id_operand_stage #(
    parameter int REGI_BITS = 4,
    parameter int REGI_SIZE = 16,
    parameter int VECT_BITS = 2,
    parameter int VECT_SIZE = 8,
    parameter int ELEM_SIZE = 8,
    parameter int CTRL_W    = 32,
    parameter int SB_BITS   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [REGI_SIZE-1:0]           pc_i,
    input  logic [CTRL_W-1:0]              ctrl_i,
    input  logic [REGI_BITS-1:0]           ra1_i,
    input  logic [REGI_BITS-1:0]           ra2_i,
    input  logic [VECT_BITS-1:0]           va1_i,
    input  logic [VECT_BITS-1:0]           va2_i,
    input  logic [3:0]                     use_i,
    input  logic [REGI_BITS-1:0]           rd_i,
    input  logic [VECT_BITS-1:0]           vd_i,
    input  logic                           int_wr_i,
    input  logic                           vec_wr_i,
    input  logic                           int_we_i,
    input  logic [REGI_BITS-1:0]           int_dest_i,
    input  logic [REGI_SIZE-1:0]           int_wd_i,
    input  logic                           vec_we_i,
    input  logic [VECT_BITS-1:0]           vec_dest_i,
    input  logic [ELEM_SIZE*VECT_SIZE-1:0] vec_wd_i,
    input  logic                           flush_i,
    input  logic                           out_ready_i,
    output logic                           out_valid_o,
    output logic [REGI_SIZE-1:0]           intOper1_o,
    output logic [REGI_SIZE-1:0]           intOper2_o,
    output logic [REGI_SIZE-1:0]           pc_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] vOper1_o,
    output logic [ELEM_SIZE*VECT_SIZE-1:0] vOper2_o,
    output logic [CTRL_W-1:0]              ctrl_o,
    output logic [REGI_BITS-1:0]           int_dest_o,
    output logic [VECT_BITS-1:0]           vec_dest_o,
    output logic                           int_wr_o,
    output logic                           vec_wr_o
);
    localparam int NI = 2**REGI_BITS;
    localparam int NV = 2**VECT_BITS;
    localparam int VW = ELEM_SIZE*VECT_SIZE;
    localparam logic [REGI_BITS-1:0] PC_IDX = '1;
    localparam logic [SB_BITS-1:0]   SB_MAX = '1;

    typedef struct packed {
        logic [REGI_SIZE-1:0] op1;
        logic [REGI_SIZE-1:0] op2;
        logic [REGI_SIZE-1:0] pc;
        logic [VW-1:0]        v1;
        logic [VW-1:0]        v2;
        logic [CTRL_W-1:0]    ctrl;
        logic [REGI_BITS-1:0] rd;
        logic [VECT_BITS-1:0] vd;
        logic                 int_wr;
        logic                 vec_wr;
    } idex_t;

    logic [NI-1:0][REGI_SIZE-1:0] iregs;
    logic [NV-1:0][VW-1:0]        vregs;
    logic [NI-1:0][SB_BITS-1:0]   icnt;
    logic [NV-1:0][SB_BITS-1:0]   vcnt;
    logic [NI-1:0]                ipend;
    logic [NV-1:0]                vpend;
    idex_t                        idex, idex_d;
    logic                         valid, hazard, fire, leave;
    logic [REGI_SIZE-1:0]         op1, op2;
    logic [VW-1:0]                v1, v2;

    // Reads: PC alias first, then same-cycle writeback bypass, then the array.
    assign op1 = (ra1_i == PC_IDX) ? pc_i :
                 (int_we_i && int_dest_i == ra1_i) ? int_wd_i : iregs[ra1_i];
    assign op2 = (ra2_i == PC_IDX) ? pc_i :
                 (int_we_i && int_dest_i == ra2_i) ? int_wd_i : iregs[ra2_i];
    assign v1  = (vec_we_i && vec_dest_i == va1_i) ? vec_wd_i : vregs[va1_i];
    assign v2  = (vec_we_i && vec_dest_i == va2_i) ? vec_wd_i : vregs[va2_i];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iregs <= '0;
            vregs <= '0;
        end else begin
            if (int_we_i && int_dest_i != PC_IDX) iregs[int_dest_i] <= int_wd_i;
            if (vec_we_i) vregs[vec_dest_i] <= vec_wd_i;
        end
    end

    assign leave = valid && out_ready_i;

    for (genvar i = 0; i < NI; i++) begin : g_isb
        if (i == NI-1) begin : g_pc
            assign icnt[i]  = '0;
            assign ipend[i] = 1'b0;
        end else begin : g_reg
            logic [SB_BITS-1:0] cnt;
            logic               inc, dec;
            assign inc = leave && !flush_i && idex.int_wr && idex.rd == REGI_BITS'(i);
            assign dec = int_we_i && int_dest_i == REGI_BITS'(i);
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) cnt <= '0;
                else if (inc && !dec && cnt != SB_MAX) cnt <= cnt + 1'b1;
                else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
            end
            assign icnt[i]  = cnt;
            // count + in-flight ID/EX writer - retiring writeback > 0
            assign ipend[i] = ({1'b0, cnt} + (SB_BITS+1)'(valid && idex.int_wr && idex.rd == REGI_BITS'(i)))
                              > (SB_BITS+1)'(dec);
        end
    end

    for (genvar i = 0; i < NV; i++) begin : g_vsb
        logic [SB_BITS-1:0] cnt;
        logic               inc, dec;
        assign inc = leave && !flush_i && idex.vec_wr && idex.vd == VECT_BITS'(i);
        assign dec = vec_we_i && vec_dest_i == VECT_BITS'(i);
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) cnt <= '0;
            else if (inc && !dec && cnt != SB_MAX) cnt <= cnt + 1'b1;
            else if (dec && !inc && cnt != '0) cnt <= cnt - 1'b1;
        end
        assign vcnt[i]  = cnt;
        assign vpend[i] = ({1'b0, cnt} + (SB_BITS+1)'(valid && idex.vec_wr && idex.vd == VECT_BITS'(i)))
                          > (SB_BITS+1)'(dec);
    end

    assign hazard = (use_i[0] && ipend[ra1_i]) || (use_i[1] && ipend[ra2_i]) ||
                    (use_i[2] && vpend[va1_i]) || (use_i[3] && vpend[va2_i]) ||
                    (int_wr_i && icnt[rd_i] == SB_MAX) ||
                    (vec_wr_i && vcnt[vd_i] == SB_MAX);

    assign in_ready_o = !hazard && (!valid || out_ready_i);
    assign fire       = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        idex_d        = '0;
        idex_d.op1    = op1;
        idex_d.op2    = op2;
        idex_d.pc     = pc_i;
        idex_d.v1     = v1;
        idex_d.v2     = v2;
        idex_d.ctrl   = ctrl_i;
        idex_d.rd     = rd_i;
        idex_d.vd     = vd_i;
        idex_d.int_wr = int_wr_i;
        idex_d.vec_wr = vec_wr_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex  <= '0;
            valid <= 1'b0;
        end else begin
            if (fire) idex <= idex_d;
            if (flush_i)    valid <= 1'b0;
            else if (fire)  valid <= 1'b1;
            else if (leave) valid <= 1'b0;
        end
    end

    assign out_valid_o = valid;
    assign intOper1_o  = idex.op1;
    assign intOper2_o  = idex.op2;
    assign pc_o        = idex.pc;
    assign vOper1_o    = idex.v1;
    assign vOper2_o    = idex.v2;
    assign ctrl_o      = idex.ctrl;
    assign int_dest_o  = idex.rd;
    assign vec_dest_o  = idex.vd;
    assign int_wr_o    = idex.int_wr;
    assign vec_wr_o    = idex.vec_wr;
endmodule

// File: tb/tb_id_operand_stage.sv
// Randomized + directed bench for id_operand_stage against a cycle-level
// architectural model (register arrays, outstanding-write counts, one ID/EX slot).
module tb_id_operand_stage;
    localparam int SBMAX = 3;

    logic        clk = 1'b0, rst;
    logic        in_valid_i, in_ready_o, int_wr_i, vec_wr_i, int_we_i, vec_we_i;
    logic        flush_i, out_ready_i, out_valid_o, int_wr_o, vec_wr_o;
    logic [15:0] pc_i, int_wd_i, intOper1_o, intOper2_o, pc_o;
    logic [31:0] ctrl_i, ctrl_o;
    logic [3:0]  ra1_i, ra2_i, rd_i, int_dest_i, use_i, int_dest_o;
    logic [1:0]  va1_i, va2_i, vd_i, vec_dest_i, vec_dest_o;
    logic [63:0] vec_wd_i, vOper1_o, vOper2_o;

    always #5 clk = ~clk;

    id_operand_stage dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .pc_i(pc_i), .ctrl_i(ctrl_i), .ra1_i(ra1_i), .ra2_i(ra2_i), .va1_i(va1_i),
        .va2_i(va2_i), .use_i(use_i), .rd_i(rd_i), .vd_i(vd_i), .int_wr_i(int_wr_i),
        .vec_wr_i(vec_wr_i), .int_we_i(int_we_i), .int_dest_i(int_dest_i),
        .int_wd_i(int_wd_i), .vec_we_i(vec_we_i), .vec_dest_i(vec_dest_i),
        .vec_wd_i(vec_wd_i), .flush_i(flush_i), .out_ready_i(out_ready_i),
        .out_valid_o(out_valid_o), .intOper1_o(intOper1_o), .intOper2_o(intOper2_o),
        .pc_o(pc_o), .vOper1_o(vOper1_o), .vOper2_o(vOper2_o), .ctrl_o(ctrl_o),
        .int_dest_o(int_dest_o), .vec_dest_o(vec_dest_o), .int_wr_o(int_wr_o),
        .vec_wr_o(vec_wr_o)
    );

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // architectural model
    logic [15:0] m_ireg [16];
    logic [63:0] m_vreg [4];
    int          m_icnt [16];
    int          m_vcnt [4];
    bit          m_valid, m_iwr, m_vwr;
    logic [15:0] m_op1, m_op2, m_pc;
    logic [63:0] m_v1, m_v2;
    logic [31:0] m_ctrl;
    logic [3:0]  m_rd;
    logic [1:0]  m_vd;

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin m_ireg[i] = '0; m_icnt[i] = 0; end
        for (int i = 0; i < 4; i++) begin m_vreg[i] = '0; m_vcnt[i] = 0; end
        m_valid = 0; m_iwr = 0; m_vwr = 0; m_op1 = '0; m_op2 = '0; m_pc = '0;
        m_v1 = '0; m_v2 = '0; m_ctrl = '0; m_rd = '0; m_vd = '0;
    endtask

    function automatic logic [15:0] rd_int(input logic [3:0] a);
        if (a == 4'd15) return pc_i;
        if (int_we_i && int_dest_i == a) return int_wd_i;
        return m_ireg[a];
    endfunction

    function automatic logic [63:0] rd_vec(input logic [1:0] a);
        if (vec_we_i && vec_dest_i == a) return vec_wd_i;
        return m_vreg[a];
    endfunction

    function automatic bit pend_int(input logic [3:0] r);
        int v;
        if (r == 4'd15) return 0;
        v = m_icnt[r] + ((m_valid && m_iwr && m_rd == r) ? 1 : 0)
                      - ((int_we_i && int_dest_i == r) ? 1 : 0);
        return v > 0;
    endfunction

    function automatic bit pend_vec(input logic [1:0] r);
        int v;
        v = m_vcnt[r] + ((m_valid && m_vwr && m_vd == r) ? 1 : 0)
                      - ((vec_we_i && vec_dest_i == r) ? 1 : 0);
        return v > 0;
    endfunction

    function automatic bit m_ready();
        bit haz;
        haz = (use_i[0] && pend_int(ra1_i)) || (use_i[1] && pend_int(ra2_i)) ||
              (use_i[2] && pend_vec(va1_i)) || (use_i[3] && pend_vec(va2_i)) ||
              (int_wr_i && rd_i != 4'd15 && m_icnt[rd_i] == SBMAX) ||
              (vec_wr_i && m_vcnt[vd_i] == SBMAX);
        return !haz && (!m_valid || out_ready_i);
    endfunction

    // Check DUT against the model for the current cycle, then advance both one clock.
    task automatic step();
        bit rdy, f, lv, inc, dec;
        #1;
        rdy = m_ready();
        chk("in_ready", in_ready_o, rdy);
        chk("out_valid", out_valid_o, m_valid);
        chk("int_oper1", intOper1_o, m_op1);
        chk("int_oper2", intOper2_o, m_op2);
        chk("pc_out", pc_o, m_pc);
        chk("v_oper1", vOper1_o, m_v1);
        chk("v_oper2", vOper2_o, m_v2);
        chk("ctrl_out", ctrl_o, m_ctrl);
        chk("dests", {int_dest_o, vec_dest_o, int_wr_o, vec_wr_o}, {m_rd, m_vd, m_iwr, m_vwr});
        f  = in_valid_i && rdy && !flush_i;
        lv = m_valid && out_ready_i;
        for (int r = 0; r < 15; r++) begin
            inc = lv && !flush_i && m_iwr && m_rd == 4'(r);
            dec = int_we_i && int_dest_i == 4'(r);
            if (inc && !dec) m_icnt[r] = (m_icnt[r] < SBMAX) ? m_icnt[r] + 1 : SBMAX;
            else if (dec && !inc && m_icnt[r] > 0) m_icnt[r] = m_icnt[r] - 1;
        end
        for (int r = 0; r < 4; r++) begin
            inc = lv && !flush_i && m_vwr && m_vd == 2'(r);
            dec = vec_we_i && vec_dest_i == 2'(r);
            if (inc && !dec) m_vcnt[r] = (m_vcnt[r] < SBMAX) ? m_vcnt[r] + 1 : SBMAX;
            else if (dec && !inc && m_vcnt[r] > 0) m_vcnt[r] = m_vcnt[r] - 1;
        end
        if (f) begin
            m_op1 = rd_int(ra1_i); m_op2 = rd_int(ra2_i); m_pc = pc_i;
            m_v1 = rd_vec(va1_i); m_v2 = rd_vec(va2_i); m_ctrl = ctrl_i;
            m_rd = rd_i; m_vd = vd_i; m_iwr = int_wr_i; m_vwr = vec_wr_i;
        end
        if (flush_i) m_valid = 0;
        else if (f)  m_valid = 1;
        else if (lv) m_valid = 0;
        if (int_we_i && int_dest_i != 4'd15) m_ireg[int_dest_i] = int_wd_i;
        if (vec_we_i) m_vreg[vec_dest_i] = vec_wd_i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid_i = 0; pc_i = '0; ctrl_i = '0; ra1_i = '0; ra2_i = '0; va1_i = '0;
        va2_i = '0; use_i = '0; rd_i = '0; vd_i = '0; int_wr_i = 0; vec_wr_i = 0;
        int_we_i = 0; int_dest_i = '0; int_wd_i = '0; vec_we_i = 0; vec_dest_i = '0;
        vec_wd_i = '0; flush_i = 0; out_ready_i = 1;
    endtask

    task automatic apply_reset();
        rst = 0;
        idle();
        #1;
        chk("rst_valid", out_valid_o, 1'b0);
        chk("rst_outs", {intOper1_o, intOper2_o, pc_o, ctrl_o, int_wr_o, vec_wr_o}, '0);
        chk("rst_vouts", {vOper1_o, vOper2_o}, '0);
        m_reset();
        @(negedge clk);
        rst = 1;
        #1 chk("rst_ready", in_ready_o, 1'b1);
    endtask

    function automatic logic [3:0] pick_ireg();
        return ($urandom_range(0, 9) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 0;
        idle();
        apply_reset();

        // writeback then read next cycle
        int_we_i = 1; int_dest_i = 4'd3; int_wd_i = 16'h1234;
        step();
        idle(); in_valid_i = 1; ra1_i = 4'd3; use_i = 4'b0001;
        step();
        chk("wb_read_valid", out_valid_o, 1'b1);
        chk("wb_read_op1", intOper1_o, 16'h1234);

        // same-cycle vector bypass
        idle(); in_valid_i = 1; va1_i = 2'd1; use_i = 4'b0100;
        vec_we_i = 1; vec_dest_i = 2'd1; vec_wd_i = 64'h0102030405060708;
        step();
        chk("vbypass", vOper1_o, 64'h0102030405060708);

        // RAW stall on r5 until its writeback
        idle(); in_valid_i = 1; rd_i = 4'd5; int_wr_i = 1;
        step();
        idle(); step();
        idle(); in_valid_i = 1; ra2_i = 4'd5; use_i = 4'b0010;
        #1 chk("raw_stall", in_ready_o, 1'b0);
        step(); step();
        int_we_i = 1; int_dest_i = 4'd5; int_wd_i = 16'hBEEF;
        #1 chk("raw_release", in_ready_o, 1'b1);
        step();
        chk("raw_valid", out_valid_o, 1'b1);
        chk("raw_op2", intOper2_o, 16'hBEEF);
        idle(); step();

        // WAW saturation on r2
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            idle(); in_valid_i = 1; rd_i = 4'd2; int_wr_i = 1;
            step();
        end
        idle(); step();
        idle(); in_valid_i = 1; rd_i = 4'd2; int_wr_i = 1;
        #1 chk("waw_stall", in_ready_o, 1'b0);
        step(); step();
        int_we_i = 1; int_dest_i = 4'd2; int_wd_i = 16'h0002;
        step();
        int_we_i = 0;
        #1 chk("waw_release", in_ready_o, 1'b1);
        step();
        chk("waw_fired", {out_valid_o, int_dest_o}, {1'b1, 4'd2});

        // backpressure hold, then flush
        apply_reset();
        idle(); in_valid_i = 1; rd_i = 4'd7; int_wr_i = 1;
        step();
        idle(); step();
        idle(); in_valid_i = 1; ra1_i = 4'd15; use_i = 4'b0001; pc_i = 16'h0040;
        rd_i = 4'd6; int_wr_i = 1; ctrl_i = 32'hCAFEF00D; out_ready_i = 0;
        step();
        chk("pc_alias", intOper1_o, 16'h0040);
        idle(); in_valid_i = 1; pc_i = 16'h1111; ra1_i = 4'd1; rd_i = 4'd8; out_ready_i = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("hold_ready", in_ready_o, 1'b0);
            chk("hold_outs", {out_valid_o, intOper1_o, pc_o, ctrl_o, int_dest_o},
                {1'b1, 16'h0040, 16'h0040, 32'hCAFEF00D, 4'd6});
        end
        flush_i = 1;
        step();
        chk("flush_valid", out_valid_o, 1'b0);
        idle(); in_valid_i = 1; ra1_i = 4'd6; use_i = 4'b0001;
        #1 chk("flush_no_inc", in_ready_o, 1'b1);
        ra1_i = 4'd7;
        #1 chk("flush_keeps_cnt", in_ready_o, 1'b0);

        // reset mid-operation with an entry held
        idle(); in_valid_i = 1; ra1_i = 4'd15; use_i = 4'b0001; pc_i = 16'h0040;
        ctrl_i = 32'h5A5A5A5A; out_ready_i = 0;
        step();
        chk("pc_alias2", {out_valid_o, intOper1_o}, {1'b1, 16'h0040});
        apply_reset();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            in_valid_i  = ($urandom_range(0, 9) < 7);
            pc_i        = 16'($urandom);
            ctrl_i      = $urandom;
            ra1_i       = pick_ireg();
            ra2_i       = pick_ireg();
            va1_i       = 2'($urandom);
            va2_i       = 2'($urandom);
            use_i       = 4'($urandom);
            rd_i        = pick_ireg();
            vd_i        = 2'($urandom);
            int_wr_i    = $urandom_range(0, 1) == 1;
            vec_wr_i    = ($urandom_range(0, 9) < 3);
            int_we_i    = ($urandom_range(0, 9) < 4);
            int_dest_i  = pick_ireg();
            int_wd_i    = 16'($urandom);
            vec_we_i    = ($urandom_range(0, 9) < 3);
            vec_dest_i  = 2'($urandom);
            vec_wd_i    = {$urandom, $urandom};
            flush_i     = ($urandom_range(0, 19) == 0);
            out_ready_i = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
